// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences one multiplexed address/data transaction on the RTC bus per start request.
module rtc_bus_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 10,
    parameter int T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_wr,
    input  logic       start_rd,
    input  logic [7:0] dir_in,
    input  logic [7:0] dato_in,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       busy,
    output logic       done
);
    localparam int MX = T_PULSE > T_SETUP ? (T_PULSE > T_HOLD ? T_PULSE : T_HOLD)
                                          : (T_SETUP > T_HOLD ? T_SETUP : T_HOLD);
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ADDR_SETUP = 3'd1;
    localparam logic [2:0] ADDR_STB   = 3'd2;
    localparam logic [2:0] ADDR_HOLD  = 3'd3;
    localparam logic [2:0] DATA_SETUP = 3'd4;
    localparam logic [2:0] DATA_STB   = 3'd5;
    localparam logic [2:0] DATA_HOLD  = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;
    logic [2:0]    state;
    logic [CW-1:0] cnt, lim;
    logic          adv, op_wr, ap, dp;
    logic [7:0]    dir, dat;
    always_comb begin
        ap  = state == ADDR_SETUP || state == ADDR_STB || state == ADDR_HOLD;
        dp  = state == DATA_SETUP || state == DATA_STB || state == DATA_HOLD;
        lim = (state == ADDR_STB || state == DATA_STB)     ? CW'(T_PULSE - 1) :
              (state == ADDR_HOLD || state == DATA_HOLD)   ? CW'(T_HOLD - 1)  :
              (state == ADDR_SETUP || state == DATA_SETUP) ? CW'(T_SETUP - 1) : '0;
        adv = cnt == lim;
    end
    // Bus outputs are registered from the current state, so they trail the state by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            dir        <= 8'h00;
            dat        <= 8'h00;
            ad_out     <= 8'h00;
            ad_oe      <= 1'b0;
            ad_sel     <= 1'b0;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            rd_n       <= 1'b1;
            dato_leido <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
                if (start_wr || start_rd) begin
                    state <= ADDR_SETUP;
                    op_wr <= start_wr;
                    dir   <= dir_in;
                    dat   <= dato_in;
                end
            end else if (adv) begin
                cnt   <= '0;
                state <= state == DONE ? IDLE : state + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            cs_n   <= !(ap || dp);
            wr_n   <= !(state == ADDR_STB || (state == DATA_STB && op_wr));
            rd_n   <= !(state == DATA_STB && !op_wr);
            ad_oe  <= ap || (dp && op_wr);
            ad_sel <= dp;
            ad_out <= ap ? dir : (dp && op_wr) ? dat : 8'h00;
            busy   <= state != IDLE;
            done   <= state == DONE;
            if (state == DATA_STB && !op_wr && adv)
                dato_leido <= ad_in;
        end
    end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed transactions on rtc_bus_ctrl, checked cycle by cycle against edge-indexed expectations.
module tb_rtc_bus_ctrl;
    logic       clk = 1'b0;
    logic       rst, start_wr, start_rd;
    logic [7:0] dir_in, dato_in, ad_in, ad_out, dato_leido;
    logic       ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, done;
    int         n_cmp = 0;
    int         n_err = 0;
    rtc_bus_ctrl #(.T_SETUP(2), .T_PULSE(10), .T_HOLD(2)) dut (
        .clk(clk), .rst(rst), .start_wr(start_wr), .start_rd(start_rd),
        .dir_in(dir_in), .dato_in(dato_in), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .ad_sel(ad_sel), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .dato_leido(dato_leido), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] bus_obs();
        return {17'b0, cs_n, wr_n, rd_n, ad_oe, ad_sel, busy, done, ad_oe ? ad_out : 8'h00};
    endfunction
    // k = edges after the start-sampling edge; outputs trail the state by one edge
    function automatic logic [31:0] bus_exp(input int k, input logic wr, input logic [7:0] dir, input logic [7:0] dat);
        logic ap, dp, astb, dstb;
        ap   = k >= 1 && k <= 14;
        dp   = k >= 15 && k <= 28;
        astb = k >= 3 && k <= 12;
        dstb = k >= 17 && k <= 26;
        return {17'b0, !(ap || dp), !(astb || (dstb && wr)), !(dstb && !wr), ap || (dp && wr), dp,
                k >= 1 && k <= 29, k == 29, ap ? dir : (dp && wr) ? dat : 8'h00};
    endfunction
    task automatic txn(input string name, input logic sw, input logic sr, input logic [7:0] dir,
                       input logic [7:0] dat, input logic [7:0] rdval, input logic [7:0] dl_before, input logic inj);
        logic wr;
        wr = sw;
        start_wr = sw;
        start_rd = sr;
        dir_in   = dir;
        dato_in  = dat;
        ad_in    = 8'hEE;
        @(posedge clk);
        #1;
        start_wr = 1'b0;
        start_rd = 1'b0;
        for (int k = 0; k <= 29; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s bus k=%0d", name, k), bus_obs(), bus_exp(k, wr, dir, dat));
            chk($sformatf("%s dato_leido k=%0d", name, k), {24'b0, dato_leido},
                {24'b0, (!wr && k >= 26) ? rdval : dl_before});
            ad_in = (k == 25 && !wr) ? rdval : 8'hEE;
            if (inj && k == 4) begin
                start_rd = 1'b1;
                dir_in   = 8'h99;
                dato_in  = 8'h88;
            end
            if (inj && k == 5)
                start_rd = 1'b0;
        end
    endtask
    task automatic idle_chk(input string name, input int n, input logic [7:0] dl);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s idle bus %0d", name, i), bus_obs(), 32'h0000_7000 | 32'(4'hE) << 11);
            chk($sformatf("%s idle dato_leido %0d", name, i), {24'b0, dato_leido}, {24'b0, dl});
        end
    endtask
    initial begin
        rst      = 1'b1;
        start_wr = 1'b0;
        start_rd = 1'b0;
        dir_in   = 8'h00;
        dato_in  = 8'h00;
        ad_in    = 8'h00;
        #2;
        chk("reset bus", bus_obs(), {17'b0, 7'b1110000, 8'h00});
        chk("reset dato_leido", {24'b0, dato_leido}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_chk("post_reset", 20, 8'h00);
        txn("write", 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 1'b0);
        txn("read", 1'b0, 1'b1, 8'h42, 8'h00, 8'h37, 8'h00, 1'b0);
        txn("write_inj", 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 8'h37, 1'b1);
        idle_chk("after_inj", 5, 8'h37);
        txn("both", 1'b1, 1'b1, 8'h5C, 8'hA3, 8'h00, 8'h37, 1'b0);
        txn("b2b_read", 1'b0, 1'b1, 8'h0F, 8'h00, 8'hC6, 8'h37, 1'b0);
        start_wr = 1'b1;
        dir_in   = 8'h33;
        dato_in  = 8'h66;
        @(posedge clk);
        #1;
        start_wr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort wr_n", {31'b0, wr_n}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort bus", bus_obs(), {17'b0, 7'b1110000, 8'h00});
        chk("abort dato_leido", {24'b0, dato_leido}, 32'h0);
        idle_chk("in_reset", 2, 8'h00);
        rst = 1'b0;
        idle_chk("after_abort", 3, 8'h00);
        txn("read_after_abort", 1'b0, 1'b1, 8'h10, 8'h00, 8'h5A, 8'h00, 1'b0);
        idle_chk("final", 3, 8'h5A);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
